// File: rtl/smoothing_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : smoothing_scheduler
// Description : Feeds a raster pixel stream to a 4-tap smoothing filter, adds
//               zero flush samples after each line, and realigns output tags.
// Revision    : 1.0 - initial release
// ============================================================================
module smoothing_scheduler #(
    parameter int LINE_W  = 640,
    parameter int LINES   = 480,
    parameter int FLUSH_N = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       filt_enb,
    output logic [7:0] filt_data,
    input  logic [7:0] filt_sum,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       frame_done
);

    localparam int CW = $clog2(LINE_W);
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int FW = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [LW-1:0] r_line;
    logic [FW-1:0] r_fcnt;
    logic          r_tag_real;
    logic          r_tag_last;
    logic          r_tag_frame;
    logic          r_pend;
    logic          r_done_seen;
    logic          w_start_ok;
    logic          w_col_last;
    logic          w_line_last;

    assign s_ready     = (r_state == ST_RUN);
    assign m_data      = filt_sum;
    assign w_start_ok  = start && !busy;
    assign w_col_last  = (r_col == CW'(LINE_W - 1));
    assign w_line_last = (r_line == LW'(LINES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_line      <= '0;
            r_fcnt      <= '0;
            r_tag_real  <= 1'b0;
            r_tag_last  <= 1'b0;
            r_tag_frame <= 1'b0;
            r_pend      <= 1'b0;
            r_done_seen <= 1'b0;
            busy        <= 1'b0;
            filt_enb    <= 1'b0;
            filt_data   <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            filt_enb    <= 1'b0;
            filt_data   <= '0;
            r_tag_real  <= 1'b0;
            r_tag_last  <= 1'b0;
            r_tag_frame <= 1'b0;

            // Tag rides one stage behind filt_enb, matching the filter's sum register.
            m_valid    <= filt_enb & r_tag_real;
            m_last     <= filt_enb & r_tag_real & r_tag_last;
            frame_done <= filt_enb & r_tag_real & r_tag_frame;

            if (w_start_ok) begin
                busy <= 1'b1;
            end else if (frame_done) begin
                busy <= 1'b0;
            end

            if (frame_done) begin
                r_done_seen <= 1'b1;
            end

            // busy can drop while the last line is still flushing; remember an early start.
            if (w_start_ok && (r_state != ST_IDLE)) begin
                r_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok || r_pend) begin
                        r_state <= ST_RUN;
                        r_col   <= '0;
                        r_line  <= '0;
                        r_pend  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (s_valid) begin
                        filt_enb    <= 1'b1;
                        filt_data   <= s_data;
                        r_tag_real  <= 1'b1;
                        r_tag_last  <= w_col_last;
                        r_tag_frame <= w_col_last && w_line_last;
                        if (w_col_last) begin
                            r_col   <= '0;
                            r_fcnt  <= '0;
                            r_state <= ST_FLUSH;
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    filt_enb <= 1'b1;
                    if (r_fcnt == FW'(FLUSH_N - 1)) begin
                        if (!w_line_last) begin
                            r_line  <= r_line + LW'(1);
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_fcnt <= r_fcnt + FW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_done_seen || frame_done) begin
                        r_done_seen <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
